// File: rtl/apb2axi_fifo_sync.sv
// ============================================================================
// Module   : apb2axi_fifo_sync
// Brief    : Single-clock valid/ready FIFO with fill level, almost-full/empty
//            flags, synchronous flush and a peak-occupancy watermark.
//            Optional output register stage: APB2AXI_FIFO_OUT_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb2axi_fifo_sync #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int CNT_W    = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_rdy,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] max_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_AF_LEVEL = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE_LEVEL = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_max_count;

  logic             w_push;
  logic             w_pop;
  logic             w_st_rd;
  logic             w_st_empty;
  logic             w_st_full;
  logic [WIDTH-1:0] w_st_head;

  // Extra pointer MSB distinguishes a full storage array from an empty one.
  assign w_st_empty = (r_wr_ptr == r_rd_ptr);
  assign w_st_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_st_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

  assign wr_rdy = ~w_st_full & ~flush;
  assign w_push = wr_vld & wr_rdy;
  assign w_pop  = rd_vld & rd_rdy;

  assign count        = r_count;
  assign max_count    = r_max_count;
  assign full         = w_st_full;
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= C_AF_LEVEL);
  assign almost_empty = (r_count <= C_AE_LEVEL);

`ifdef APB2AXI_FIFO_OUT_REG_EN
  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Refill the output register whenever it is empty or being drained.
  always_comb begin
    w_state_nxt = r_state;
    w_st_rd     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (!w_st_empty) begin
          w_st_rd     = 1'b1;
          w_state_nxt = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (w_pop) begin
          if (!w_st_empty) begin
            w_st_rd = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_data <= '0;
    end else if (flush) begin
      r_out_data <= '0;
    end else if (w_st_rd) begin
      r_out_data <= w_st_head;
    end
  end

  assign rd_vld  = (r_state == ST_LOADED) & ~flush;
  assign rd_data = r_out_data;
`else
  assign rd_vld  = ~w_st_empty & ~flush;
  assign rd_data = w_st_head;
  assign w_st_rd = w_pop;
`endif

  // Storage array carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_st_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_max_count <= '0;
    end else if (flush) begin
      r_max_count <= '0;
    end else if (r_count > r_max_count) begin
      r_max_count <= r_count;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb2axi_fifo_sync.sv
// ============================================================================
// Module   : tb_apb2axi_fifo_sync
// Brief    : Directed self-checking bench for apb2axi_fifo_sync (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb2axi_fifo_sync;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 2);

  logic             clk = 1'b0;
  logic             resetn;
  logic             flush;
  logic             wr_vld;
  logic [WIDTH-1:0] wr_data;
  logic             wr_rdy;
  logic             rd_vld;
  logic [WIDTH-1:0] rd_data;
  logic             rd_rdy;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] max_count;

  int n_checks = 0;
  int n_fails  = 0;

  apb2axi_fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .wr_vld       (wr_vld),
    .wr_data      (wr_data),
    .wr_rdy       (wr_rdy),
    .rd_vld       (rd_vld),
    .rd_data      (rd_data),
    .rd_rdy       (rd_rdy),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .max_count    (max_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr_rdy"}, wr_rdy, 1);
    check_eq({tag, "_rd_vld"}, rd_vld, 0);
    check_eq({tag, "_count"}, count, 0);
    check_eq({tag, "_max"}, max_count, 0);
    check_eq({tag, "_full"}, full, 0);
    check_eq({tag, "_empty"}, empty, 1);
    check_eq({tag, "_ae"}, almost_empty, 1);
    check_eq({tag, "_af"}, almost_full, 0);
  endtask

  initial begin
    resetn  = 1'b0;
    flush   = 1'b0;
    wr_vld  = 1'b0;
    wr_data = '0;
    rd_rdy  = 1'b0;
    #23;
    check_reset_outputs("rst");
    tick();
    resetn = 1'b1;
    tick();

    // Fill to full with rd_rdy low.
    wr_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = i;
      tick();
      check_eq("fill_count", count, i + 1);
      check_eq("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
      if (i == 0) begin
        check_eq("fwft_vld", rd_vld, 1);
        check_eq("fwft_data", rd_data, 32'h0);
      end
    end
    wr_data = 32'h99;
    #1;
    check_eq("full_flag", full, 1);
    check_eq("full_wr_rdy", wr_rdy, 0);
    tick();
    check_eq("full_refuse_cnt", count, 16);
    check_eq("full_max", max_count, 16);

    // Simultaneous push/pop while full: only the pop happens.
    wr_data = 32'hAA;
    rd_rdy  = 1'b1;
    #1;
    check_eq("fullpop_data", rd_data, 32'h0);
    tick();
    wr_vld = 1'b0;
    #1;
    check_eq("fullpop_count", count, 15);
    check_eq("fullpop_full", full, 0);

    // Drain the rest in order.
    for (int k = 1; k < 16; k++) begin
      check_eq("drain_vld", rd_vld, 1);
      check_eq("drain_data", rd_data, k);
      tick();
      check_eq("drain_count", count, 15 - k);
      check_eq("drain_ae", almost_empty, (15 - k <= 2) ? 1 : 0);
    end
    rd_rdy = 1'b0;
    #1;
    check_eq("drain_empty", empty, 1);
    check_eq("drain_rd_vld", rd_vld, 0);

    // Steady streaming at count=5 across pointer wraps.
    wr_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 32'h100 + i;
      tick();
    end
    check_eq("stream_pre_cnt", count, 5);
    rd_rdy = 1'b1;
    for (int j = 0; j < 40; j++) begin
      wr_data = 32'h105 + j;
      #1;
      check_eq("stream_data", rd_data, 32'h100 + j);
      tick();
      check_eq("stream_count", count, 5);
    end
    rd_rdy = 1'b0;

    // Bring count to 9, then flush with a concurrent push.
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'h300 + i;
      tick();
    end
    check_eq("preflush_cnt", count, 9);
    check_eq("preflush_max", max_count, 16);
    flush   = 1'b1;
    wr_data = 32'hDEAD;
    #1;
    check_eq("flush_wr_rdy", wr_rdy, 0);
    check_eq("flush_rd_vld", rd_vld, 0);
    tick();
    flush  = 1'b0;
    wr_vld = 1'b0;
    #1;
    check_eq("postflush_cnt", count, 0);
    check_eq("postflush_max", max_count, 0);
    check_eq("postflush_vld", rd_vld, 0);
    check_eq("postflush_empty", empty, 1);
    wr_vld  = 1'b1;
    wr_data = 32'h55;
    tick();
    wr_vld = 1'b0;
    #1;
    check_eq("postflush_rd", rd_data, 32'h55);
    check_eq("postflush_cnt1", count, 1);

    // Async reset mid-burst, between clock edges.
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    wr_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h60 + i;
      tick();
    end
    check_eq("burst_cnt", count, 3);
    #2;
    resetn = 1'b0;
    wr_vld = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    resetn = 1'b1;
    tick();
    wr_vld  = 1'b1;
    wr_data = 32'h77;
    tick();
    wr_vld = 1'b0;
    #1;
    check_eq("arst_rd_vld", rd_vld, 1);
    check_eq("arst_rd_data", rd_data, 32'h77);
    check_eq("arst_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
